// File: rtl/fetch_pkg.sv
// Shared fetch-side types and defaults for the instruction fetch queue.
package fetch_pkg;

    localparam int FQ_DEPTH       = 8;
    localparam int FQ_FETCH_WIDTH = 2;

    typedef logic [31:0] fetch_data_t;

    typedef struct packed {
        logic [63:0] pc;
        fetch_data_t instr;
        logic        pred_taken;
        logic [63:0] pred_target;
    } fetch_entry_t;

endpackage

// File: rtl/fq_compact.sv
// Turns a sparse per-lane valid mask into dense write offsets and a lane count.
module fq_compact #(
    parameter int FETCH_WIDTH = 2,
    parameter int OFF_W       = $clog2(FETCH_WIDTH + 1)
) (
    input  logic [FETCH_WIDTH-1:0]            laneValid,
    output logic [FETCH_WIDTH-1:0][OFF_W-1:0] laneOffset,
    output logic [OFF_W-1:0]                  nEnq
);

    logic [OFF_W-1:0] runSum;

    // Each lane's slot is the number of valid lanes below it.
    always_comb begin
        runSum     = '0;
        laneOffset = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            laneOffset[i] = runSum;
            runSum        = runSum + OFF_W'(laneValid[i]);
        end
        nEnq = runSum;
    end

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch-to-decode instruction queue with sparse-lane compaction.
// Define FETCH_QUEUE_PERF_EN to add the full/empty cycle performance counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int FETCH_WIDTH = FQ_FETCH_WIDTH,
    parameter int DEPTH       = FQ_DEPTH
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic [FETCH_WIDTH-1:0]        enq_valid,
    input  fetch_entry_t [FETCH_WIDTH-1:0] enq_entry,
    output logic                          enq_ready,
    output logic [FETCH_WIDTH-1:0]        deq_valid,
    output fetch_entry_t [FETCH_WIDTH-1:0] deq_entry,
    input  logic                          deq_ready,
    output logic [$clog2(DEPTH):0]        count
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]                   perf_full_cycles,
    output logic [31:0]                   perf_empty_cycles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(FETCH_WIDTH + 1);

    logic [AW-1:0]                 head, tail;
    fetch_entry_t                  storage [DEPTH];
    logic [FETCH_WIDTH-1:0][OW-1:0] laneOffset;
    logic [OW-1:0]                 nEnq;
    logic                          enqFire, deqFire;
    logic [CW-1:0]                 nDeq, enqAmt, deqAmt;

    fq_compact #(.FETCH_WIDTH(FETCH_WIDTH), .OFF_W(OW)) uCompact (
        .laneValid (enq_valid),
        .laneOffset(laneOffset),
        .nEnq      (nEnq)
    );

    // Readiness looks only at registered occupancy so fetch sees no comb path.
    assign enq_ready = (CW'(DEPTH) - count) >= CW'(FETCH_WIDTH);
    assign enqFire   = enq_ready && (|enq_valid) && !flush;
    assign deqFire   = deq_ready && (count != '0) && !flush;
    assign nDeq      = (count < CW'(FETCH_WIDTH)) ? count : CW'(FETCH_WIDTH);
    assign enqAmt    = enqFire ? CW'(nEnq) : '0;
    assign deqAmt    = deqFire ? nDeq : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(deqAmt);
            tail  <= tail + AW'(enqAmt);
            count <= count + enqAmt - deqAmt;
        end
    end

    // Storage is deliberately left unreset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (enqFire && enq_valid[i])
                storage[tail + AW'(laneOffset[i])] <= enq_entry[i];
        end
    end

    always_comb begin
        deq_valid = '0;
        deq_entry = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            deq_valid[i] = (count > CW'(i)) && !flush;
            deq_entry[i] = storage[head + AW'(i)];
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_full_cycles  <= '0;
            perf_empty_cycles <= '0;
        end else begin
            if ((|enq_valid) && !enq_ready)
                perf_full_cycles <= perf_full_cycles + 32'd1;
            if ((count == '0) && !flush)
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
        end
    end
`endif

endmodule
